// File: rtl/alu.sv
// Clocked ALU: eight operations on A/B, result and status flags
// captured together in one output register (1-cycle latency).
module alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_Sel,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             Zero_Flag,
    output logic             Carry_Flag,
    output logic             Negative_Flag,
    output logic             Overflow_Flag
);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] r;
    logic             c;
    logic             v;

    // Extra top bit holds the add carry-out / subtract borrow.
    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op_e'(ALU_Sel))
            OP_ADD: begin
                r = sum[MSB:0];
                c = sum[WIDTH];
                v = (A[MSB] == B[MSB]) && (r[MSB] != A[MSB]);
            end
            OP_SUB: begin
                r = diff[MSB:0];
                c = diff[WIDTH];
                v = (A[MSB] != B[MSB]) && (r[MSB] != A[MSB]);
            end
            OP_AND: r = A & B;
            OP_OR:  r = A | B;
            OP_XOR: r = A ^ B;
            OP_NOT: r = ~A;
            OP_SHL: begin
                r = {A[MSB-1:0], 1'b0};
                c = A[MSB];
            end
            OP_SHR: begin
                r = {1'b0, A[MSB:1]};
                c = A[0];
            end
            default: begin
                r = '0;
                c = 1'b0;
                v = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ALU_Out       <= '0;
            Zero_Flag     <= 1'b1;
            Carry_Flag    <= 1'b0;
            Negative_Flag <= 1'b0;
            Overflow_Flag <= 1'b0;
        end else begin
            ALU_Out       <= r;
            Zero_Flag     <= (r == '0);
            Carry_Flag    <= c;
            Negative_Flag <= r[MSB];
            Overflow_Flag <= v;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: vector table plus reset/latency sequences.
module tb_alu;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [2:0] ALU_Sel;
    logic [7:0] ALU_Out;
    logic       Zero_Flag;
    logic       Carry_Flag;
    logic       Negative_Flag;
    logic       Overflow_Flag;

    int tests;
    int fails;

    alu #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .A             (A),
        .B             (B),
        .ALU_Sel       (ALU_Sel),
        .ALU_Out       (ALU_Out),
        .Zero_Flag     (Zero_Flag),
        .Carry_Flag    (Carry_Flag),
        .Negative_Flag (Negative_Flag),
        .Overflow_Flag (Overflow_Flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] sel;
        logic [7:0] out;
        logic       z;
        logic       c;
        logic       n;
        logic       v;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] out,
                         input logic z, input logic c,
                         input logic n, input logic v);
        tests++;
        if (ALU_Out !== out || Zero_Flag !== z || Carry_Flag !== c ||
            Negative_Flag !== n || Overflow_Flag !== v) begin
            fails++;
            $display("FAIL %s: got out=%0d z=%b c=%b n=%b v=%b, expected out=%0d z=%b c=%b n=%b v=%b",
                     name, ALU_Out, Zero_Flag, Carry_Flag, Negative_Flag,
                     Overflow_Flag, out, z, c, n, v);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] sel);
        @(negedge clk);
        A       = a;
        B       = b;
        ALU_Sel = sel;
    endtask

    task automatic add_vec(input string name, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] sel,
                           input logic [7:0] out, input logic z,
                           input logic c, input logic n, input logic v);
        vec_t t;
        t.name = name; t.a = a; t.b = b; t.sel = sel;
        t.out = out; t.z = z; t.c = c; t.n = n; t.v = v;
        vecs.push_back(t);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        A = 8'hFF; B = 8'h01; ALU_Sel = 3'b000;

        //       name         A      B      sel     out    z c n v
        add_vec("add_10_5",   8'd10, 8'd5,  3'b000, 8'd15, 0,0,0,0);
        add_vec("sub_10_5",   8'd10, 8'd5,  3'b001, 8'd5,  0,0,0,0);
        add_vec("and_10_5",   8'd10, 8'd5,  3'b010, 8'd0,  1,0,0,0);
        add_vec("or_10_5",    8'd10, 8'd5,  3'b011, 8'd15, 0,0,0,0);
        add_vec("xor_10_5",   8'd10, 8'd5,  3'b100, 8'd15, 0,0,0,0);
        add_vec("add_0_5",    8'd0,  8'd5,  3'b000, 8'd5,  0,0,0,0);
        add_vec("not_0",      8'd0,  8'd5,  3'b101, 8'd255,0,0,1,0);
        add_vec("shl_0",      8'd0,  8'd5,  3'b110, 8'd0,  1,0,0,0);
        add_vec("shr_0",      8'd0,  8'd5,  3'b111, 8'd0,  1,0,0,0);
        add_vec("add_carry",  8'd200,8'd100,3'b000, 8'd44, 0,1,0,0);
        add_vec("add_ovf",    8'd100,8'd100,3'b000, 8'd200,0,0,1,1);
        add_vec("sub_borrow", 8'd5,  8'd10, 3'b001, 8'd251,0,1,1,0);
        add_vec("shl_81",     8'h81, 8'd0,  3'b110, 8'h02, 0,1,0,0);
        add_vec("shr_81",     8'h81, 8'd0,  3'b111, 8'h40, 0,1,0,0);
        add_vec("add_80_80",  8'h80, 8'h80, 3'b000, 8'h00, 1,1,0,1);
        add_vec("sub_80_1",   8'h80, 8'h01, 3'b001, 8'h7F, 0,0,0,1);
        add_vec("add_ff_1",   8'hFF, 8'h01, 3'b000, 8'h00, 1,1,0,0);
        add_vec("sub_eq",     8'h37, 8'h37, 3'b001, 8'h00, 1,0,0,0);
        add_vec("xor_f0_ff",  8'hF0, 8'hFF, 3'b100, 8'h0F, 0,0,0,0);
        add_vec("not_55",     8'h55, 8'hFF, 3'b101, 8'hAA, 0,0,1,0);
        add_vec("shl_msb",    8'hC0, 8'h00, 3'b110, 8'h80, 0,1,1,0);
        add_vec("and_after_c",8'hFF, 8'hFF, 3'b010, 8'hFF, 0,0,1,0);

        // Reset held two edges with live inputs.
        @(posedge clk); #1;
        check("rst_edge1", 8'd0, 1, 0, 0, 0);
        @(posedge clk); #1;
        check("rst_edge2", 8'd0, 1, 0, 0, 0);

        drive(8'd10, 8'd5, 3'b000);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_release", 8'd15, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].sel);
            @(posedge clk); #1;
            check(vecs[i].name, vecs[i].out, vecs[i].z, vecs[i].c,
                  vecs[i].n, vecs[i].v);
        end

        // Inputs changed right after an edge must not show until next edge.
        drive(8'd200, 8'd100, 3'b000);
        @(posedge clk); #1;
        check("lat_first", 8'd44, 0, 1, 0, 0);
        A = 8'd5; B = 8'd10; ALU_Sel = 3'b001;
        #2;
        check("lat_hold_a", 8'd44, 0, 1, 0, 0);
        @(negedge clk); #3;
        check("lat_hold_b", 8'd44, 0, 1, 0, 0);
        @(posedge clk); #1;
        check("lat_update", 8'd251, 0, 1, 1, 0);

        // Reset on the same edge as a new op wins.
        drive(8'd100, 8'd100, 3'b000);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_wins", 8'd0, 1, 0, 0, 0);
        drive(8'h81, 8'h00, 3'b111);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_op", 8'h40, 0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
